// File: rtl/ahbl_master_arbiter.sv
// Two-master AHB-Lite arbiter: each master's address phase is parked in a pending
// register, one pending transfer is issued per bus cycle, and data/ready are steered back.
module ahbl_master_arbiter #(
    parameter int ARB_MODE = 0,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic [AW-1:0] M0_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic          M0_HWRITE,
    input  logic [2:0]    M0_HSIZE,
    input  logic [DW-1:0] M0_HWDATA,
    output logic          M0_HREADY,
    output logic [DW-1:0] M0_HRDATA,
    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M1_HTRANS,
    input  logic          M1_HWRITE,
    input  logic [2:0]    M1_HSIZE,
    input  logic [DW-1:0] M1_HWDATA,
    output logic          M1_HREADY,
    output logic [DW-1:0] M1_HRDATA,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [DW-1:0] HWDATA,
    input  logic          HREADY,
    input  logic [DW-1:0] HRDATA
);

    logic [AW-1:0] m_haddr  [2];
    logic [1:0]    m_htrans [2];
    logic          m_hwrite [2];
    logic [2:0]    m_hsize  [2];
    logic          m_ready  [2];
    logic          m_cap    [2];

    logic [1:0]    pend_v_q;
    logic [AW-1:0] pend_addr_q  [2];
    logic [1:0]    pend_write_q;
    logic [2:0]    pend_size_q  [2];
    logic [1:0]    dph_q;
    logic          lock_q;
    logic          sel_q;
    logic          rr_q;

    logic          win_valid;
    logic          win;
    logic          issue;

    assign m_haddr[0]  = M0_HADDR;
    assign m_haddr[1]  = M1_HADDR;
    assign m_htrans[0] = M0_HTRANS;
    assign m_htrans[1] = M1_HTRANS;
    assign m_hwrite[0] = M0_HWRITE;
    assign m_hwrite[1] = M1_HWRITE;
    assign m_hsize[0]  = M0_HSIZE;
    assign m_hsize[1]  = M1_HSIZE;

    // A master is stalled while its own transfer waits for the bus, and otherwise
    // sees the bus ready only while it owns the data phase.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign m_ready[gi] = pend_v_q[gi] ? 1'b0 : (dph_q[gi] ? HREADY : 1'b1);
            assign m_cap[gi]   = m_ready[gi] &&
                                 ((m_htrans[gi] == 2'b10) || (m_htrans[gi] == 2'b11));
        end
    endgenerate

    always_comb begin
        win_valid = |pend_v_q;
        win       = 1'b0;
        if (lock_q) begin
            win = sel_q;
        end else if (&pend_v_q) begin
            win = (ARB_MODE == 1) ? ~rr_q : 1'b0;
        end else begin
            win = pend_v_q[1];
        end
    end

    assign issue = win_valid && HREADY;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend_v_q     <= '0;
            pend_write_q <= '0;
            dph_q        <= '0;
            lock_q       <= 1'b0;
            sel_q        <= 1'b0;
            rr_q         <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                pend_addr_q[i] <= '0;
                pend_size_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_cap[i]) begin
                    pend_v_q[i]     <= 1'b1;
                    pend_addr_q[i]  <= m_haddr[i];
                    pend_write_q[i] <= m_hwrite[i];
                    pend_size_q[i]  <= m_hsize[i];
                end else if (issue && (win == i[0])) begin
                    pend_v_q[i] <= 1'b0;
                end
            end
            if (issue) begin
                dph_q  <= win ? 2'b10 : 2'b01;
                rr_q   <= win;
                lock_q <= 1'b0;
            end else begin
                if (HREADY) begin
                    dph_q <= '0;
                end
                // Freeze the selection so a stalled address phase cannot change under the slave.
                if (win_valid) begin
                    lock_q <= 1'b1;
                    sel_q  <= win;
                end
            end
        end
    end

    assign HTRANS    = win_valid ? 2'b10 : 2'b00;
    assign HADDR     = win_valid ? pend_addr_q[win] : '0;
    assign HWRITE    = win_valid ? pend_write_q[win] : 1'b0;
    assign HSIZE     = win_valid ? pend_size_q[win] : 3'b000;
    assign HWDATA    = dph_q[0] ? M0_HWDATA : (dph_q[1] ? M1_HWDATA : '0);
    assign M0_HREADY = m_ready[0];
    assign M1_HREADY = m_ready[1];
    assign M0_HRDATA = dph_q[0] ? HRDATA : '0;
    assign M1_HRDATA = dph_q[1] ? HRDATA : '0;

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Directed bench for ahbl_master_arbiter: instance 0 is fixed priority, instance 1 round-robin.
module tb_ahbl_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_haddr [2], m1_haddr [2], haddr [2];
    logic [1:0]  m0_htrans[2], m1_htrans[2], htrans[2];
    logic        m0_hwrite[2], m1_hwrite[2], hwrite[2];
    logic [2:0]  m0_hsize [2], m1_hsize [2], hsize [2];
    logic [31:0] m0_hwdata[2], m1_hwdata[2], hwdata[2];
    logic [31:0] m0_hrdata[2], m1_hrdata[2], hrdata[2];
    logic        m0_hready[2], m1_hready[2], hready[2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            ahbl_master_arbiter #(.ARB_MODE(gi), .AW(32), .DW(32)) u_dut (
                .HCLK(clk), .HRESET(rst),
                .M0_HADDR(m0_haddr[gi]), .M0_HTRANS(m0_htrans[gi]), .M0_HWRITE(m0_hwrite[gi]),
                .M0_HSIZE(m0_hsize[gi]), .M0_HWDATA(m0_hwdata[gi]), .M0_HREADY(m0_hready[gi]),
                .M0_HRDATA(m0_hrdata[gi]),
                .M1_HADDR(m1_haddr[gi]), .M1_HTRANS(m1_htrans[gi]), .M1_HWRITE(m1_hwrite[gi]),
                .M1_HSIZE(m1_hsize[gi]), .M1_HWDATA(m1_hwdata[gi]), .M1_HREADY(m1_hready[gi]),
                .M1_HRDATA(m1_hrdata[gi]),
                .HADDR(haddr[gi]), .HTRANS(htrans[gi]), .HWRITE(hwrite[gi]), .HSIZE(hsize[gi]),
                .HWDATA(hwdata[gi]), .HREADY(hready[gi]), .HRDATA(hrdata[gi])
            );
        end
    endgenerate

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            m0_haddr[i] = '0; m0_htrans[i] = 2'b00; m0_hwrite[i] = 1'b0; m0_hsize[i] = 3'b000;
            m0_hwdata[i] = '0;
            m1_haddr[i] = '0; m1_htrans[i] = 2'b00; m1_hwrite[i] = 1'b0; m1_hsize[i] = 3'b000;
            m1_hwdata[i] = '0;
            hready[i] = 1'b1;
            hrdata[i] = 32'hA5A5_0000 + i;
        end
    endtask

    task automatic quiet(input int n);
        idle_all();
        repeat (n) next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        settle();
        for (int i = 0; i < 2; i++) begin
            tests++; if (htrans[i] !== 2'b00) begin fails++; $display("FAIL reset_htrans[%0d]: got %b want 00", i, htrans[i]); end
            tests++; if (haddr[i] !== 32'h0) begin fails++; $display("FAIL reset_haddr[%0d]: got %h want 0", i, haddr[i]); end
            tests++; if (hwrite[i] !== 1'b0 || hsize[i] !== 3'b000) begin fails++; $display("FAIL reset_ctrl[%0d]: got %b/%b want 0/000", i, hwrite[i], hsize[i]); end
            tests++; if (hwdata[i] !== 32'h0) begin fails++; $display("FAIL reset_hwdata[%0d]: got %h want 0", i, hwdata[i]); end
            tests++; if (m0_hready[i] !== 1'b1 || m1_hready[i] !== 1'b1) begin fails++; $display("FAIL reset_hready[%0d]: got %b%b want 11", i, m0_hready[i], m1_hready[i]); end
            tests++; if (m0_hrdata[i] !== 32'h0 || m1_hrdata[i] !== 32'h0) begin fails++; $display("FAIL reset_hrdata[%0d]: got %h/%h want 0/0", i, m0_hrdata[i], m1_hrdata[i]); end
        end
    endtask

    task automatic test_single_read();
        next_cycle();
        m0_haddr[0] = 32'h2000_0010; m0_htrans[0] = 2'b10; m0_hsize[0] = 3'b010;
        hrdata[0] = 32'h1234_5678;
        settle();
        tests++; if (m0_hready[0] !== 1'b1 || htrans[0] !== 2'b00) begin fails++; $display("FAIL rd_c1: got hready=%b htrans=%b want 1/00", m0_hready[0], htrans[0]); end
        next_cycle();
        m0_htrans[0] = 2'b00;
        settle();
        tests++; if (haddr[0] !== 32'h2000_0010 || htrans[0] !== 2'b10) begin fails++; $display("FAIL rd_c2_addr: got %h/%b want 20000010/10", haddr[0], htrans[0]); end
        tests++; if (hwrite[0] !== 1'b0 || hsize[0] !== 3'b010) begin fails++; $display("FAIL rd_c2_ctrl: got %b/%b want 0/010", hwrite[0], hsize[0]); end
        tests++; if (m0_hready[0] !== 1'b0) begin fails++; $display("FAIL rd_c2_hready: got %b want 0", m0_hready[0]); end
        next_cycle();
        settle();
        tests++; if (m0_hready[0] !== 1'b1 || m0_hrdata[0] !== 32'h1234_5678) begin fails++; $display("FAIL rd_c3_data: got %b/%h want 1/12345678", m0_hready[0], m0_hrdata[0]); end
        tests++; if (m1_hrdata[0] !== 32'h0 || htrans[0] !== 2'b00) begin fails++; $display("FAIL rd_c3_other: got %h/%b want 0/00", m1_hrdata[0], htrans[0]); end
        next_cycle();
        settle();
        tests++; if (m0_hrdata[0] !== 32'h0) begin fails++; $display("FAIL rd_c4_hrdata: got %h want 0", m0_hrdata[0]); end
        quiet(2);
    endtask

    task automatic test_fixed_priority();
        next_cycle();
        m0_haddr[0] = 32'h0000_0000; m0_htrans[0] = 2'b10;
        m1_haddr[0] = 32'h4000_0004; m1_htrans[0] = 2'b10;
        hrdata[0] = 32'h0BEE_F00D;
        next_cycle();
        m0_htrans[0] = 2'b00; m1_htrans[0] = 2'b00;
        settle();
        tests++; if (htrans[0] !== 2'b10 || haddr[0] !== 32'h0) begin fails++; $display("FAIL fp_c2_addr: got %h/%b want 00000000/10", haddr[0], htrans[0]); end
        tests++; if (m0_hready[0] !== 1'b0 || m1_hready[0] !== 1'b0) begin fails++; $display("FAIL fp_c2_hready: got %b%b want 00", m0_hready[0], m1_hready[0]); end
        next_cycle();
        settle();
        tests++; if (htrans[0] !== 2'b10 || haddr[0] !== 32'h4000_0004) begin fails++; $display("FAIL fp_c3_addr: got %h/%b want 40000004/10", haddr[0], htrans[0]); end
        tests++; if (m0_hready[0] !== 1'b1 || m1_hready[0] !== 1'b0) begin fails++; $display("FAIL fp_c3_hready: got %b%b want 10", m0_hready[0], m1_hready[0]); end
        tests++; if (m0_hrdata[0] !== 32'h0BEE_F00D || m1_hrdata[0] !== 32'h0) begin fails++; $display("FAIL fp_c3_hrdata: got %h/%h want 0beef00d/0", m0_hrdata[0], m1_hrdata[0]); end
        next_cycle();
        settle();
        tests++; if (m1_hready[0] !== 1'b1 || m1_hrdata[0] !== 32'h0BEE_F00D || htrans[0] !== 2'b00) begin fails++; $display("FAIL fp_c4: got %b/%h/%b want 1/0beef00d/00", m1_hready[0], m1_hrdata[0], htrans[0]); end
        quiet(2);
    endtask

    task automatic test_round_robin();
        int cnt0, cnt1, grants;
        logic s0, s1;
        logic [31:0] exp_addr;
        // One lone M0 transfer leaves M1 next in line for the following tie.
        next_cycle();
        m0_haddr[1] = 32'h0F00_0000; m0_htrans[1] = 2'b10;
        next_cycle();
        m0_htrans[1] = 2'b00;
        settle();
        tests++; if (htrans[1] !== 2'b10 || haddr[1] !== 32'h0F00_0000) begin fails++; $display("FAIL rr_warmup: got %h/%b want 0f000000/10", haddr[1], htrans[1]); end
        quiet(2);
        cnt0 = 0; cnt1 = 0; grants = 0;
        for (int cyc = 0; cyc < 40 && grants < 8; cyc++) begin
            m0_htrans[1] = (cnt0 < 4) ? 2'b10 : 2'b00;
            m0_haddr[1]  = 32'h1000_0000 + 32'(cnt0 * 4);
            m1_htrans[1] = (cnt1 < 4) ? 2'b10 : 2'b00;
            m1_haddr[1]  = 32'h2000_0000 + 32'(cnt1 * 4);
            settle();
            s0 = m0_hready[1] && m0_htrans[1][1];
            s1 = m1_hready[1] && m1_htrans[1][1];
            if (htrans[1] === 2'b10) begin
                exp_addr = ((grants % 2) == 0) ? 32'h2000_0000 : 32'h1000_0000;
                exp_addr = exp_addr + 32'((grants / 2) * 4);
                tests++; if (haddr[1] !== exp_addr) begin fails++; $display("FAIL rr_grant%0d: got %h want %h", grants, haddr[1], exp_addr); end
                grants++;
            end
            if (s0) cnt0++;
            if (s1) cnt1++;
            next_cycle();
        end
        tests++; if (grants != 8) begin fails++; $display("FAIL rr_count: got %0d grants want 8", grants); end
        quiet(3);
    endtask

    task automatic test_write_wait();
        next_cycle();
        m1_haddr[0] = 32'h5000_0000; m1_htrans[0] = 2'b10; m1_hwrite[0] = 1'b1; m1_hsize[0] = 3'b010;
        next_cycle();
        m1_htrans[0] = 2'b00; m1_hwdata[0] = 32'hCAFE_F00D;
        m0_haddr[0] = 32'h3000_0008; m0_htrans[0] = 2'b10; m0_hwdata[0] = 32'h0BAD_0000;
        hrdata[0] = 32'h55AA_33CC;
        settle();
        tests++; if (haddr[0] !== 32'h5000_0000 || htrans[0] !== 2'b10 || hwrite[0] !== 1'b1) begin fails++; $display("FAIL wr_c2_addr: got %h/%b/%b want 50000000/10/1", haddr[0], htrans[0], hwrite[0]); end
        tests++; if (hwdata[0] !== 32'h0 || m1_hready[0] !== 1'b0) begin fails++; $display("FAIL wr_c2_data: got %h/%b want 0/0", hwdata[0], m1_hready[0]); end
        for (int w = 0; w < 4; w++) begin
            next_cycle();
            m0_htrans[0] = 2'b00;
            hready[0] = (w == 3);
            settle();
            tests++; if (hwdata[0] !== 32'hCAFE_F00D) begin fails++; $display("FAIL wr_hwdata_w%0d: got %h want cafef00d", w, hwdata[0]); end
            tests++; if (m1_hready[0] !== (w == 3)) begin fails++; $display("FAIL wr_hready_w%0d: got %b want %b", w, m1_hready[0], (w == 3)); end
            tests++; if (haddr[0] !== 32'h3000_0008 || htrans[0] !== 2'b10 || m0_hready[0] !== 1'b0) begin fails++; $display("FAIL wr_stall_w%0d: got %h/%b/%b want 30000008/10/0", w, haddr[0], htrans[0], m0_hready[0]); end
        end
        next_cycle();
        settle();
        tests++; if (hwdata[0] !== 32'h0BAD_0000 || m0_hrdata[0] !== 32'h55AA_33CC) begin fails++; $display("FAIL wr_m0_dph: got %h/%h want 0bad0000/55aa33cc", hwdata[0], m0_hrdata[0]); end
        tests++; if (htrans[0] !== 2'b00 || m0_hready[0] !== 1'b1 || m1_hready[0] !== 1'b1) begin fails++; $display("FAIL wr_end: got %b/%b%b want 00/11", htrans[0], m0_hready[0], m1_hready[0]); end
        quiet(2);
    endtask

    task automatic test_lock();
        next_cycle();
        m1_haddr[0] = 32'h6000_0000; m1_htrans[0] = 2'b10;
        next_cycle();
        m1_htrans[0] = 2'b00;
        m0_haddr[0] = 32'h7000_0000; m0_htrans[0] = 2'b10;
        hready[0] = 1'b0;
        settle();
        tests++; if (haddr[0] !== 32'h6000_0000 || htrans[0] !== 2'b10) begin fails++; $display("FAIL lock_c2: got %h/%b want 60000000/10", haddr[0], htrans[0]); end
        next_cycle();
        m0_htrans[0] = 2'b00;
        hready[0] = 1'b1;
        settle();
        tests++; if (haddr[0] !== 32'h6000_0000) begin fails++; $display("FAIL lock_hold: got %h want 60000000", haddr[0]); end
        next_cycle();
        settle();
        tests++; if (haddr[0] !== 32'h7000_0000 || htrans[0] !== 2'b10) begin fails++; $display("FAIL lock_next: got %h/%b want 70000000/10", haddr[0], htrans[0]); end
        quiet(3);
    endtask

    task automatic test_reset_mid();
        next_cycle();
        m1_haddr[0] = 32'h9000_0000; m1_htrans[0] = 2'b10;
        next_cycle();
        m1_htrans[0] = 2'b00;
        m0_haddr[0] = 32'h8000_0000; m0_htrans[0] = 2'b10;
        next_cycle();
        m0_htrans[0] = 2'b00;
        hready[0] = 1'b0;
        settle();
        tests++; if (m1_hready[0] !== 1'b0 || m0_hready[0] !== 1'b0 || haddr[0] !== 32'h8000_0000) begin fails++; $display("FAIL rstmid_pre: got %b%b/%h want 00/80000000", m0_hready[0], m1_hready[0], haddr[0]); end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        hready[0] = 1'b1;
        settle();
        tests++; if (htrans[0] !== 2'b00 || m0_hready[0] !== 1'b1 || m1_hready[0] !== 1'b1) begin fails++; $display("FAIL rstmid_post: got %b/%b%b want 00/11", htrans[0], m0_hready[0], m1_hready[0]); end
        tests++; if (m1_hrdata[0] !== 32'h0 || hwdata[0] !== 32'h0) begin fails++; $display("FAIL rstmid_data: got %h/%h want 0/0", m1_hrdata[0], hwdata[0]); end
        next_cycle();
        settle();
        tests++; if (htrans[0] !== 2'b00) begin fails++; $display("FAIL rstmid_late: got %b want 00", htrans[0]); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fixed_priority();
        test_round_robin();
        test_write_wait();
        test_lock();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
